// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide sequencer: op encodings, FSM states
// and default latencies.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MSUB  = 3'b110,
        OP_MSUBU = 3'b111
    } muldiv_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } muldiv_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    function automatic logic op_is_div(muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage <-> multiply/divide unit signal bundle.
//
// Handshake: start is a single-cycle request that the unit accepts only while
// Busy=0 and cancel=0; there is no separate ready, ~Busy is the ready. Requests
// (start or we) raised while Busy=1 are ignored, the hazard unit must stall them.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        we;
    logic        hilo_sel;
    logic [31:0] WD;
    logic        cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, op, A, B, we, hilo_sel, WD, cancel,
        input  Busy, HI, LO
    );

    modport slave (
        input  start, op, A, B, we, hilo_sel, WD, cancel,
        output Busy, HI, LO
    );
endinterface

// File: rtl/muldiv_arith.sv
// Combinational 64-bit result for every mult/div op, including the divide-by-zero
// and signed-overflow results. Accumulate ops exist only under MULDIV_MADD_EN.
module muldiv_arith
    import muldiv_pkg::*;
(
    input  muldiv_op_e  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0]        s_prod;
    logic [63:0]        u_prod;
    logic               div_zero;
    logic               s_ovf;
    logic signed [31:0] sa;
    logic signed [31:0] sb_safe;
    logic [31:0]        ub_safe;
    logic [31:0]        s_quo;
    logic [31:0]        s_rem;
    logic [31:0]        u_quo;
    logic [31:0]        u_rem;

    assign s_prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign u_prod = {32'b0, a} * {32'b0, b};

    assign div_zero = (b == 32'd0);
    assign s_ovf    = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // The divider never sees 0 or the overflowing pair; those results are muxed in below.
    assign sa      = $signed(a);
    assign sb_safe = (div_zero || s_ovf) ? 32'sd1 : $signed(b);
    assign ub_safe = div_zero ? 32'd1 : b;

    assign s_quo = sa / sb_safe;
    assign s_rem = sa % sb_safe;
    assign u_quo = a / ub_safe;
    assign u_rem = a % ub_safe;

`ifndef MULDIV_MADD_EN
    logic unused_hilo;
    assign unused_hilo = ^{hi, lo};
`endif

    always_comb begin
        result = 64'd0;
        case (op)
            OP_MULT:  result = s_prod;
            OP_MULTU: result = u_prod;
            OP_DIV: begin
                if (div_zero)   result = {a, 32'hFFFF_FFFF};
                else if (s_ovf) result = {32'd0, 32'h8000_0000};
                else            result = {s_rem, s_quo};
            end
            OP_DIVU: begin
                if (div_zero) result = {a, 32'hFFFF_FFFF};
                else          result = {u_rem, u_quo};
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  result = {hi, lo} + s_prod;
            OP_MADDU: result = {hi, lo} + u_prod;
            OP_MSUB:  result = {hi, lo} - s_prod;
            OP_MSUBU: result = {hi, lo} - u_prod;
`endif
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: fixed-latency busy window, mthi/mtlo writes,
// flush on cancel. Optional madd/msub family is enabled by `define MULDIV_MADD_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_if.slave       bus,
    output muldiv_state_e state_dbg
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    muldiv_state_e state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [63:0]   pend_q, pend_n;
    logic [31:0]   hi_q, hi_n;
    logic [31:0]   lo_q, lo_n;
    logic [63:0]   result;
    logic          op_ok;
    muldiv_op_e    op;

    assign op = muldiv_op_e'(bus.op);

    muldiv_arith u_arith (
        .op     (op),
        .a      (bus.A),
        .b      (bus.B),
        .hi     (hi_q),
        .lo     (lo_q),
        .result (result)
    );

`ifdef MULDIV_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~bus.op[2];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 64'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            pend_q  <= pend_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
        end
    end

    // cancel outranks everything, including the commit on the final RUN cycle.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        pend_n  = pend_q;
        hi_n    = hi_q;
        lo_n    = lo_q;
        case (state_q)
            IDLE: begin
                if (bus.cancel) begin
                    pend_n = 64'd0;
                end else if (bus.start && op_ok) begin
                    pend_n  = result;
                    cnt_n   = op_is_div(op) ? DIV_LOAD : MULT_LOAD;
                    state_n = RUN;
                end else if (bus.we) begin
                    if (bus.hilo_sel) hi_n = bus.WD;
                    else              lo_n = bus.WD;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    pend_n  = 64'd0;
                end else if (cnt_q == '0) begin
                    hi_n    = pend_q[63:32];
                    lo_n    = pend_q[31:0];
                    pend_n  = 64'd0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.Busy  = (state_q == RUN);
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign state_dbg = state_q;

endmodule
